// File: rtl/dpram_init_checker_if.sv
// dpram_init_checker_if
//   RAM-side bus between dpram_init_checker and a true dual-port RAM.
//   Both ports share address/data widths; read data is expected one cycle
//   after the address is presented (synchronous read).
//
//   Signals:
//     we_a, we_b        port write enables
//     addr_a, addr_b    port addresses            [ADDR_WIDTH-1:0]
//     wdata_a, wdata_b  port write data           [DATA_WIDTH-1:0]
//     rdata_a, rdata_b  port read data            [DATA_WIDTH-1:0]
//
//   Modports:
//     master  the checker: drives enables/addresses/write data, takes read data
//     slave   the RAM: takes enables/addresses/write data, drives read data
`timescale 1ns/1ps

interface dpram_init_checker_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
);
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;

  modport master (
    output we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/dpram_init_checker.sv
// dpram_init_checker
//   Fills a true dual-port RAM through both ports in parallel with the
//   pattern P(addr) = (3*addr + SEED) mod 2^DATA_WIDTH (port A takes the even
//   address 2k, port B the odd address 2k+1), then reads the whole array back
//   through both ports and counts words that differ from the pattern.
//
//   Build option:
//     DPRAM_INIT_CHECKER_READBACK_EN  defined   : WRITE -> READ -> DRAIN -> DONE
//                                     undefined : WRITE -> DONE, no compare;
//                                                 error/err_count stay 0 and
//                                                 read data is ignored.
//
//   Ports:
//     clk        clock, all logic on posedge
//     rst        synchronous active-high reset; all outputs return to 0
//     start      one-cycle request, accepted only in IDLE or DONE
//     busy       high in WRITE, READ and DRAIN
//     done       high in DONE until the next accepted start or reset
//     error      sticky mismatch flag, cleared on accepted start
//     err_count  saturating mismatch count, cleared on accepted start
//     bus        RAM bus (master modport), all outputs registered
`timescale 1ns/1ps

module dpram_init_checker #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12,
  parameter int SEED       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           err_count,
  dpram_init_checker_if.master  bus
);

  localparam int KW = ADDR_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] SEED_T = DATA_WIDTH'(SEED);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
`ifdef DPRAM_INIT_CHECKER_READBACK_EN
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] a;
    a = DATA_WIDTH'(addr);
    return a + a + a + SEED_T;
  endfunction

  logic [2:0]            state_q;
  logic [2:0]            nxt_state;
  logic [KW-1:0]         k_q;
  logic [KW-1:0]         nxt_k;
  logic                  accept;

  logic                  nxt_we;
  logic                  nxt_busy;
  logic                  nxt_sweep;
  logic [ADDR_WIDTH-1:0] nxt_addr_a;
  logic [ADDR_WIDTH-1:0] nxt_addr_b;
  logic [DATA_WIDTH-1:0] nxt_wdata_a;
  logic [DATA_WIDTH-1:0] nxt_wdata_b;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q;
  logic [DATA_WIDTH-1:0] wdata_b_q;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    nxt_state = state_q;
    nxt_k     = k_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt_state = S_WRITE;
          nxt_k     = '0;
        end
      end
      S_WRITE: begin
        nxt_k = k_q + KW'(1);
        if (&k_q) begin
`ifdef DPRAM_INIT_CHECKER_READBACK_EN
          nxt_state = S_READ;
`else
          nxt_state = S_DONE;
`endif
        end
      end
`ifdef DPRAM_INIT_CHECKER_READBACK_EN
      S_READ: begin
        nxt_k = k_q + KW'(1);
        if (&k_q) nxt_state = S_DRAIN;
      end
      S_DRAIN: nxt_state = S_DONE;
`endif
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered yet
  // line up with the state they belong to (addr_a=0 right after the start edge).
  always_comb begin
    nxt_we = (nxt_state == S_WRITE);
`ifdef DPRAM_INIT_CHECKER_READBACK_EN
    nxt_sweep = nxt_we || (nxt_state == S_READ);
    nxt_busy  = nxt_sweep || (nxt_state == S_DRAIN);
`else
    nxt_sweep = nxt_we;
    nxt_busy  = nxt_we;
`endif
    nxt_addr_a  = nxt_sweep ? {nxt_k, 1'b0} : '0;
    nxt_addr_b  = nxt_sweep ? {nxt_k, 1'b1} : '0;
    nxt_wdata_a = nxt_we ? pat({nxt_k, 1'b0}) : '0;
    nxt_wdata_b = nxt_we ? pat({nxt_k, 1'b1}) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_q      <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
    end else begin
      state_q   <= nxt_state;
      k_q       <= nxt_k;
      busy      <= nxt_busy;
      done      <= (nxt_state == S_DONE);
      we_q      <= nxt_we;
      addr_a_q  <= nxt_addr_a;
      addr_b_q  <= nxt_addr_b;
      wdata_a_q <= nxt_wdata_a;
      wdata_b_q <= nxt_wdata_b;
    end
  end

  assign bus.we_a    = we_q;
  assign bus.we_b    = we_q;
  assign bus.addr_a  = addr_a_q;
  assign bus.addr_b  = addr_b_q;
  assign bus.wdata_a = wdata_a_q;
  assign bus.wdata_b = wdata_b_q;

`ifdef DPRAM_INIT_CHECKER_READBACK_EN
  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] m);
    logic [16:0] s;
    s = {1'b0, cnt} + {15'b0, m};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic          vld_p0;
  logic [KW-1:0] k_p0;
  logic          mis_a;
  logic          mis_b;
  logic [1:0]    mis_cnt;

  // p0: remember which step was just read; its data arrives next cycle
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= (state_q == S_READ);
  end

  always_ff @(posedge clk) begin
    k_p0 <= k_q;
  end

  // p1: compare RAM data against the pattern of the remembered addresses
  assign mis_a   = vld_p0 && (bus.rdata_a != pat({k_p0, 1'b0}));
  assign mis_b   = vld_p0 && (bus.rdata_b != pat({k_p0, 1'b1}));
  assign mis_cnt = {1'b0, mis_a} + {1'b0, mis_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (mis_cnt != 2'd0) begin
      error     <= 1'b1;
      err_count <= sat_add(err_count, mis_cnt);
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^{bus.rdata_a, bus.rdata_b, accept};
  assign error        = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_dpram_init_checker.sv
// tb_dpram_init_checker
//   Directed bench for dpram_init_checker with two instances (SEED=0, SEED=1)
//   each wired to a behavioural synchronous dual-port RAM. Expectations follow
//   the build option DPRAM_INIT_CHECKER_READBACK_EN.
`timescale 1ns/1ps

module tb_dpram_init_checker;

  localparam int AW = 10;
  localparam int DW = 12;
  localparam int D  = 1024;
`ifdef DPRAM_INIT_CHECKER_READBACK_EN
  localparam int EXP_LAT = 1025;
  localparam bit RB      = 1'b1;
`else
  localparam int EXP_LAT = 512;
  localparam bit RB      = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, start0, start1;
  logic        busy0, done0, error0, busy1, done1, error1;
  logic [15:0] cnt0, cnt1;

  dpram_init_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  dpram_init_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  dpram_init_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .error(error0), .err_count(cnt0), .bus(bus0.master)
  );

  dpram_init_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .error(error1), .err_count(cnt1), .bus(bus1.master)
  );

  logic [DW-1:0] mem0 [D];
  logic [DW-1:0] mem1 [D];
  bit clr0, clr1, corrupt_b7, stuck_a;

  always @(posedge clk) begin
    if (clr0) begin
      for (int i = 0; i < D; i++) mem0[i] <= '0;
    end else begin
      if (bus0.we_a) mem0[bus0.addr_a] <= bus0.wdata_a;
      if (bus0.we_b) mem0[bus0.addr_b] <= bus0.wdata_b;
    end
    bus0.rdata_a <= mem0[bus0.addr_a];
    bus0.rdata_b <= mem0[bus0.addr_b] ^ ((corrupt_b7 && bus0.addr_b == 10'd7) ? 12'h001 : 12'h000);
  end

  always @(posedge clk) begin
    if (clr1) begin
      for (int i = 0; i < D; i++) mem1[i] <= '0;
    end else begin
      if (bus1.we_a) mem1[bus1.addr_a] <= bus1.wdata_a;
      if (bus1.we_b) mem1[bus1.addr_b] <= bus1.wdata_b;
    end
    bus1.rdata_a <= stuck_a ? 12'h000 : mem1[bus1.addr_a];
    bus1.rdata_b <= mem1[bus1.addr_b];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pat(input int a, input int seed);
    return (3 * a + seed) % 4096;
  endfunction

  function automatic int ram_bad(input bit which, input int seed);
    int bad = 0;
    for (int i = 0; i < D; i++) begin
      if (int'(which ? mem1[i] : mem0[i]) != pat(i, seed)) bad++;
    end
    return bad;
  endfunction

  logic [AW-1:0] s_aa0, s_ab0, s_aa1;
  logic [DW-1:0] s_wa0, s_wb0, s_wa1, s_wb1;
  logic [1:0]    s_we0;
  logic          s_busy0;

  // Pulse start, then count edges after E0 until done is seen (bounded).
  task automatic run(input bit which, input int again_at, output int lat);
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    s_aa0 = bus0.addr_a; s_ab0 = bus0.addr_b; s_wa0 = bus0.wdata_a;
    s_wb0 = bus0.wdata_b; s_we0 = {bus0.we_a, bus0.we_b}; s_busy0 = busy0;
    lat = -1;
    for (int n = 1; n <= 4000; n++) begin
      if (n == again_at) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      if (n == 1) begin
        s_aa1 = bus0.addr_a; s_wa1 = bus0.wdata_a; s_wb1 = bus0.wdata_b;
      end
      if ((which ? done1 : done0) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic clear_ram0();
    @(negedge clk) clr0 = 1'b1;
    @(negedge clk) clr0 = 1'b0;
  endtask

  int lat;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    clr0 = 1'b1; clr1 = 1'b1; corrupt_b7 = 1'b0; stuck_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;

    // reset state
    check("rst_flags", {busy0, done0, error0, bus0.we_a, bus0.we_b}, 0);
    check("rst_addr", {bus0.addr_a, bus0.addr_b}, 0);
    check("rst_wdata", {bus0.wdata_a, bus0.wdata_b}, 0);
    check("rst_cnt", cnt0, 0);

    // clean run, SEED=0
    run(1'b0, 0, lat);
    check("clean_lat", lat, EXP_LAT);
    check("step0_addr", {s_aa0, s_ab0}, {10'd0, 10'd1});
    check("step0_wdata", {s_wa0, s_wb0}, {12'd0, 12'd3});
    check("step0_ctl", {s_we0, s_busy0}, 3'b111);
    check("step1_addr_a", s_aa1, 2);
    check("step1_wdata", {s_wa1, s_wb1}, {12'd6, 12'd9});
    check("clean_err", {error0, busy0}, 0);
    check("clean_cnt", cnt0, 0);
    check("ram5", mem0[5], 15);
    check("ram1022", mem0[1022], 3066);
    check("ram1023", mem0[1023], 3069);
    check("clean_ram_bad", ram_bad(1'b0, 0), 0);
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", done0, 1);
    check("done_bus", {bus0.we_a, bus0.addr_b, bus0.wdata_b}, 0);

    // port B read of address 7 corrupted
    corrupt_b7 = 1'b1;
    run(1'b0, 0, lat);
    corrupt_b7 = 1'b0;
    check("corrupt_lat", lat, EXP_LAT);
    check("corrupt_err", error0, RB ? 1 : 0);
    check("corrupt_cnt", cnt0, RB ? 1 : 0);

    // SEED=1, port A read data stuck at 0
    stuck_a = 1'b1;
    run(1'b1, 0, lat);
    stuck_a = 1'b0;
    check("stuck_lat", lat, EXP_LAT);
    check("stuck_err", error1, RB ? 1 : 0);
    check("stuck_cnt", cnt1, RB ? 512 : 0);
    check("seed1_ram0", mem1[0], 1);
    check("seed1_ram1023", mem1[1023], 3070);
    check("seed1_ram_bad", ram_bad(1'b1, 1), 0);

    // a new clean start clears error/count left by a failing run
    run(1'b1, 0, lat);
    check("reclear_cnt", {error1, cnt1}, 0);

    // second start while busy is ignored
    clear_ram0();
    run(1'b0, 300, lat);
    check("busy_start_lat", lat, EXP_LAT);
    check("busy_start_ram_bad", ram_bad(1'b0, 0), 0);
    check("busy_start_cnt", {error0, cnt0}, 0);

    // reset at E100 during WRITE
    clear_ram0();
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("pre_rst_busy", busy0, 1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    check("mid_rst_ctl", {busy0, done0, bus0.we_a, bus0.we_b}, 0);
    check("mid_rst_addr", {bus0.addr_a, bus0.addr_b}, 0);
    check("mid_rst_ram199", mem0[199], 597);
    check("mid_rst_ram200", mem0[200], 0);
    run(1'b0, 0, lat);
    check("post_rst_lat", lat, EXP_LAT);
    check("post_rst_cnt", {error0, cnt0}, 0);
    check("post_rst_ram_bad", ram_bad(1'b0, 0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
